// File: rtl/uart_pkg.sv
`default_nettype none
// =====================================================================
// uart_pkg : parity modes, FSM encodings and counter sizing for uart_ng
// Revision : 1.0 - initial release
// =====================================================================
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;
  localparam int OVERSAMPLE  = 16;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  // Bits needed to hold values 0..value-1, never less than one.
  function automatic int log2(input int value);
    int result;
    result = 1;
    while ((1 << result) < value) result = result + 1;
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// =====================================================================
// uart_baud_tick : free-running divider, one tick every DIV clocks
// Revision       : 1.0 - initial release
// =====================================================================
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            CW   = log2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule
`default_nettype wire

// File: rtl/uart_ng.sv
`default_nettype none
// =====================================================================
// uart_ng  : full-duplex 16x-oversampled UART with sticky errors and idle timeout
// Revision : 1.0 - initial release
// =====================================================================
module uart_ng
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 100000000,
  parameter int BAUD_RATE    = 115200,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int TIMEOUT_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic                 tx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_busy,
  output logic                 rx_timeout,
  output logic                 err_frame,
  output logic                 err_parity,
  output logic                 err_overrun,
  input  logic                 err_clear
);

  localparam int         DIV        = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int         TW         = log2(TIMEOUT_BITS + 1);
  localparam logic [3:0] LAST_DATA  = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP  = 4'(STOP_BITS - 1);
  localparam logic       ODD_FLIP   = (PARITY == PARITY_ODD);
  localparam bit         HAS_PARITY = (PARITY != PARITY_NONE);

  generate
    if (DIV < 1 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
        (PARITY != PARITY_NONE && PARITY != PARITY_ODD && PARITY != PARITY_EVEN)) begin : g_param_check
      $error("uart_ng: illegal parameter set (DIV must be >= 1)");
    end
  endgenerate

  logic tick;

  uart_baud_tick #(.DIV(DIV)) u_baud_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  logic rx_meta, rxs, rxs_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
    end
  end

  rx_state_t            rx_state;
  logic [3:0]           rx_phase, rx_bits, idle_phase;
  logic [DATA_BITS-1:0] rx_shift;
  logic [TW-1:0]        idle_bits;
  logic                 s7, s8, rx_bit, rx_par_bad, idle_armed;
  logic                 vote, start_edge;

  // Majority of the phase-7/8 samples and the live phase-9 level.
  assign vote       = (s7 & s8) | (s7 & rxs) | (s8 & rxs);
  assign start_edge = rxs_d & ~rxs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state    <= RX_IDLE;
      rx_phase    <= 4'd0;
      rx_bits     <= 4'd0;
      rx_shift    <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_busy     <= 1'b0;
      rx_timeout  <= 1'b0;
      s7          <= 1'b1;
      s8          <= 1'b1;
      rx_bit      <= 1'b1;
      rx_par_bad  <= 1'b0;
      idle_phase  <= 4'd0;
      idle_bits   <= '0;
      idle_armed  <= 1'b0;
      err_frame   <= 1'b0;
      err_parity  <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      rx_timeout <= 1'b0;
      if (err_clear) begin
        err_frame   <= 1'b0;
        err_parity  <= 1'b0;
        err_overrun <= 1'b0;
      end
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (tick) begin
        if (rx_phase == 4'd7) s7 <= rxs;
        if (rx_phase == 4'd8) s8 <= rxs;
        if (rx_phase == 4'd9) rx_bit <= vote;
        rx_phase <= (rx_phase == 4'd15) ? 4'd0 : rx_phase + 4'd1;
      end
      case (rx_state)
        RX_IDLE: begin
          if (start_edge) begin
            rx_state   <= RX_START;
            rx_phase   <= 4'd0;
            rx_busy    <= 1'b1;
            rx_par_bad <= 1'b0;
            idle_armed <= 1'b0;
            idle_bits  <= '0;
          end else if (idle_armed && rxs && tick) begin
            // The first wrap closes the stop bit; TIMEOUT_BITS more wraps are idle bits.
            if (idle_phase == 4'd15) begin
              idle_phase <= 4'd0;
              if (idle_bits == TW'(TIMEOUT_BITS)) begin
                rx_timeout <= 1'b1;
                idle_armed <= 1'b0;
              end else begin
                idle_bits <= idle_bits + TW'(1);
              end
            end else begin
              idle_phase <= idle_phase + 4'd1;
            end
          end
        end
        RX_START: begin
          if (tick && rx_phase == 4'd8 && rxs) begin
            rx_state <= RX_IDLE;
            rx_busy  <= 1'b0;
          end else if (tick && rx_phase == 4'd15) begin
            rx_state <= RX_DATA;
            rx_bits  <= 4'd0;
          end
        end
        RX_DATA: begin
          if (tick && rx_phase == 4'd15) begin
            rx_shift <= {rx_bit, rx_shift[DATA_BITS-1:1]};
            if (rx_bits == LAST_DATA) begin
              rx_state <= HAS_PARITY ? RX_PARITY : RX_STOP;
            end else begin
              rx_bits <= rx_bits + 4'd1;
            end
          end
        end
        RX_PARITY: begin
          if (tick && rx_phase == 4'd15) begin
            rx_par_bad <= rx_bit ^ (^rx_shift) ^ ODD_FLIP;
            rx_state   <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (tick && rx_phase == 4'd9) begin
            rx_state   <= RX_IDLE;
            rx_busy    <= 1'b0;
            idle_armed <= 1'b1;
            idle_phase <= 4'd10;
            idle_bits  <= '0;
            if (!vote) err_frame <= 1'b1;
            if (rx_par_bad) err_parity <= 1'b1;
            if (vote && !rx_par_bad) begin
              if (!rx_valid || rx_ready) begin
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
              end else begin
                err_overrun <= 1'b1;
              end
            end
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  tx_state_t            tx_state;
  logic [3:0]           tx_phase, tx_bits;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par, tx_bit_end;

  assign tx_ready   = (tx_state == TX_IDLE);
  assign tx_bit_end = tick && (tx_phase == 4'd15);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= TX_IDLE;
      tx       <= 1'b1;
      tx_phase <= 4'd0;
      tx_bits  <= 4'd0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
    end else begin
      if (tick && tx_state != TX_IDLE) tx_phase <= (tx_phase == 4'd15) ? 4'd0 : tx_phase + 4'd1;
      case (tx_state)
        TX_IDLE: begin
          tx <= 1'b1;
          if (tx_valid) begin
            tx_shift <= tx_data;
            tx_par   <= (^tx_data) ^ ODD_FLIP;
            tx_state <= TX_START;
            tx_phase <= 4'd0;
          end
        end
        TX_START: begin
          // tx still high means the start bit begins on this tick.
          if (tick && tx) begin
            tx       <= 1'b0;
            tx_phase <= 4'd0;
          end else if (tx_bit_end) begin
            tx_state <= TX_DATA;
            tx       <= tx_shift[0];
            tx_bits  <= 4'd0;
          end
        end
        TX_DATA: begin
          if (tx_bit_end) begin
            if (tx_bits == LAST_DATA) begin
              tx_state <= HAS_PARITY ? TX_PARITY : TX_STOP;
              tx       <= HAS_PARITY ? tx_par : 1'b1;
              tx_bits  <= 4'd0;
            end else begin
              tx_bits  <= tx_bits + 4'd1;
              tx_shift <= tx_shift >> 1;
              tx       <= tx_shift[1];
            end
          end
        end
        TX_PARITY: begin
          if (tx_bit_end) begin
            tx_state <= TX_STOP;
            tx       <= 1'b1;
            tx_bits  <= 4'd0;
          end
        end
        TX_STOP: begin
          if (tx_bit_end) begin
            if (tx_bits == LAST_STOP) tx_state <= TX_IDLE;
            else tx_bits <= tx_bits + 4'd1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_ng.sv
`default_nettype none
// =====================================================================
// tb_uart_ng : randomized self-checking bench, 8N1 and 8E1 instances at DIV = 1
// Revision   : 1.0 - initial release
// =====================================================================
module tb_uart_ng;

  localparam int CLK_FREQ  = 1600000;
  localparam int BAUD_RATE = 100000;
  localparam int BIT       = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       rx_n = 1'b1, tx_n, tx_valid_n = 1'b0, tx_ready_n, rx_valid_n, rx_ready_n = 1'b0;
  logic       rx_busy_n, rx_timeout_n, err_frame_n, err_parity_n, err_overrun_n, err_clear_n = 1'b0;
  logic [7:0] tx_data_n = 8'h00, rx_data_n;

  logic       rx_e = 1'b1, tx_e, tx_valid_e = 1'b0, tx_ready_e, rx_valid_e, rx_ready_e = 1'b0;
  logic       rx_busy_e, rx_timeout_e, err_frame_e, err_parity_e, err_overrun_e, err_clear_e = 1'b0;
  logic [7:0] tx_data_e = 8'h00, rx_data_e;

  uart_ng #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .DATA_BITS(8), .PARITY(0),
            .STOP_BITS(1), .TIMEOUT_BITS(4)) u_n (
    .clk(clk), .rst(rst), .rx(rx_n), .tx(tx_n), .tx_data(tx_data_n), .tx_valid(tx_valid_n),
    .tx_ready(tx_ready_n), .rx_data(rx_data_n), .rx_valid(rx_valid_n), .rx_ready(rx_ready_n),
    .rx_busy(rx_busy_n), .rx_timeout(rx_timeout_n), .err_frame(err_frame_n),
    .err_parity(err_parity_n), .err_overrun(err_overrun_n), .err_clear(err_clear_n)
  );

  uart_ng #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .DATA_BITS(8), .PARITY(2),
            .STOP_BITS(1), .TIMEOUT_BITS(4)) u_e (
    .clk(clk), .rst(rst), .rx(rx_e), .tx(tx_e), .tx_data(tx_data_e), .tx_valid(tx_valid_e),
    .tx_ready(tx_ready_e), .rx_data(rx_data_e), .rx_valid(rx_valid_e), .rx_ready(rx_ready_e),
    .rx_busy(rx_busy_e), .rx_timeout(rx_timeout_e), .err_frame(err_frame_e),
    .err_parity(err_parity_e), .err_overrun(err_overrun_e), .err_clear(err_clear_e)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int timeouts = 0;
  logic [7:0] rx_model[$];

  always @(posedge clk) if (rx_timeout_n) timeouts <= timeouts + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Serial frame onto one of the two rx lines; par < 0 means no parity bit.
  task automatic drive_frame(input bit on_e, input logic [7:0] data, input int par, input logic stop);
    logic seq[$];
    seq.push_back(1'b0);
    for (int i = 0; i < 8; i++) seq.push_back(data[i]);
    if (par >= 0) seq.push_back(par[0]);
    seq.push_back(stop);
    foreach (seq[k]) begin
      @(posedge clk);
      #1;
      if (on_e) rx_e = seq[k]; else rx_n = seq[k];
      repeat (BIT - 1) @(posedge clk);
    end
    @(posedge clk);
    #1;
    if (on_e) rx_e = 1'b1; else rx_n = 1'b1;
  endtask

  // Send one byte on u_n and compare every bit centre with the 8N1 frame model.
  task automatic tx_frame(input logic [7:0] d, input string name);
    int   g;
    logic exp_bit;
    tx_data_n  = d;
    tx_valid_n = 1'b1;
    g = 0;
    while (tx_ready_n !== 1'b1 && g < 400) begin @(negedge clk); g++; end
    n_cmp++;
    if (tx_ready_n !== 1'b1) begin n_bad++; $display("FAIL %s_accept: tx_ready got %b want 1", name, tx_ready_n); end
    @(posedge clk);
    #1 tx_valid_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      repeat (i == 0 ? 9 : 16) @(posedge clk);
      #2;
      exp_bit = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : d[i-1];
      n_cmp++;
      if (tx_n !== exp_bit) begin n_bad++; $display("FAIL %s_bit%0d: tx got %b want %b", name, i, tx_n, exp_bit); end
      if (i == 1) begin
        n_cmp++;
        if (tx_ready_n !== 1'b0) begin n_bad++; $display("FAIL %s_busy: tx_ready got %b want 0", name, tx_ready_n); end
      end
    end
    repeat (7) @(posedge clk);
    #2;
    n_cmp++;
    if (tx_ready_n !== 1'b0) begin n_bad++; $display("FAIL %s_ready160: tx_ready got %b want 0", name, tx_ready_n); end
    @(posedge clk);
    #2;
    n_cmp++;
    if ({tx_ready_n, tx_n} !== 2'b11) begin n_bad++; $display("FAIL %s_ready161: ready,tx got %b want 11", name, {tx_ready_n, tx_n}); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({tx_n, tx_ready_n, rx_valid_n, rx_busy_n, rx_timeout_n, err_frame_n, err_parity_n, err_overrun_n, rx_data_n} !== 16'hC000) begin
      n_bad++;
      $display("FAIL reset_state: got %h want c000",
               {tx_n, tx_ready_n, rx_valid_n, rx_busy_n, rx_timeout_n, err_frame_n, err_parity_n, err_overrun_n, rx_data_n});
    end
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_tx();
    tx_frame(8'hA5, "tx_a5");
    for (int k = 0; k < 3; k++) tx_frame(8'($urandom), "tx_rand");
  endtask

  task automatic test_rx_random();
    logic [7:0] d, want;
    rx_ready_n = 1'b0;
    for (int k = 0; k < 5; k++) begin
      d = 8'($urandom);
      rx_model.push_back(d);
      drive_frame(1'b0, d, -1, 1'b1);
      @(negedge clk);
      want = rx_model.pop_front();
      n_cmp++;
      if ({rx_valid_n, rx_data_n} !== {1'b1, want}) begin
        n_bad++; $display("FAIL rx_rand%0d: valid,data got %b,%h want 1,%h", k, rx_valid_n, rx_data_n, want);
      end
      n_cmp++;
      if ({rx_busy_n, err_frame_n, err_parity_n, err_overrun_n} !== 4'b0000) begin
        n_bad++; $display("FAIL rx_rand%0d_flags: busy,errs got %b want 0000", k, {rx_busy_n, err_frame_n, err_parity_n, err_overrun_n});
      end
      @(posedge clk); #1 rx_ready_n = 1'b1;
      @(posedge clk); #1 rx_ready_n = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (rx_valid_n !== 1'b0) begin n_bad++; $display("FAIL rx_rand%0d_consume: rx_valid got %b want 0", k, rx_valid_n); end
    end
  endtask

  task automatic test_glitch();
    @(posedge clk); #1 rx_n = 1'b0;
    repeat (5) @(posedge clk); #1 rx_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (rx_busy_n !== 1'b1) begin n_bad++; $display("FAIL glitch_busy: rx_busy got %b want 1", rx_busy_n); end
    repeat (30) @(negedge clk);
    n_cmp++;
    if ({rx_busy_n, rx_valid_n, err_frame_n, err_parity_n, err_overrun_n} !== 5'b00000) begin
      n_bad++; $display("FAIL glitch_reject: busy,valid,errs got %b want 00000",
                        {rx_busy_n, rx_valid_n, err_frame_n, err_parity_n, err_overrun_n});
    end
    drive_frame(1'b0, 8'h3C, -1, 1'b1);
    @(negedge clk);
    n_cmp++;
    if ({rx_valid_n, rx_data_n} !== {1'b1, 8'h3C}) begin
      n_bad++; $display("FAIL glitch_next: valid,data got %b,%h want 1,3c", rx_valid_n, rx_data_n);
    end
    @(posedge clk); #1 rx_ready_n = 1'b1;
    @(posedge clk); #1 rx_ready_n = 1'b0;
  endtask

  task automatic test_parity();
    logic [7:0] d;
    d = 8'($urandom);
    drive_frame(1'b1, d, $countones(d) % 2, 1'b1);
    @(negedge clk);
    n_cmp++;
    if ({rx_valid_e, rx_data_e, err_parity_e} !== {1'b1, d, 1'b0}) begin
      n_bad++; $display("FAIL par_rand: valid,data,perr got %b,%h,%b want 1,%h,0", rx_valid_e, rx_data_e, err_parity_e, d);
    end
    @(posedge clk); #1 rx_ready_e = 1'b1;
    @(posedge clk); #1 rx_ready_e = 1'b0;
    drive_frame(1'b1, 8'h07, 1, 1'b1);
    @(negedge clk);
    n_cmp++;
    if ({rx_valid_e, rx_data_e, err_frame_e, err_parity_e, err_overrun_e} !== {1'b1, 8'h07, 3'b000}) begin
      n_bad++; $display("FAIL par_good07: valid,data,errs got %b,%h,%b want 1,07,000",
                        rx_valid_e, rx_data_e, {err_frame_e, err_parity_e, err_overrun_e});
    end
    @(posedge clk); #1 rx_ready_e = 1'b1;
    @(posedge clk); #1 rx_ready_e = 1'b0;
    drive_frame(1'b1, 8'h07, 0, 1'b1);
    @(negedge clk);
    n_cmp++;
    if ({rx_valid_e, err_parity_e, err_frame_e} !== 3'b010) begin
      n_bad++; $display("FAIL par_bad07: valid,perr,ferr got %b want 010", {rx_valid_e, err_parity_e, err_frame_e});
    end
  endtask

  task automatic test_overrun();
    rx_ready_n = 1'b0;
    drive_frame(1'b0, 8'h11, -1, 1'b1);
    drive_frame(1'b0, 8'h22, -1, 1'b1);
    @(negedge clk);
    n_cmp++;
    if ({rx_valid_n, rx_data_n, err_overrun_n} !== {1'b1, 8'h11, 1'b1}) begin
      n_bad++; $display("FAIL overrun: valid,data,ovr got %b,%h,%b want 1,11,1", rx_valid_n, rx_data_n, err_overrun_n);
    end
    @(posedge clk); #1 err_clear_n = 1'b1;
    @(posedge clk); #1 err_clear_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({err_overrun_n, rx_valid_n} !== 2'b01) begin
      n_bad++; $display("FAIL overrun_clear: ovr,valid got %b want 01", {err_overrun_n, rx_valid_n});
    end
    @(posedge clk); #1 rx_ready_n = 1'b1;
    @(posedge clk); #1 rx_ready_n = 1'b0;
  endtask

  task automatic test_frame_timeout();
    int base;
    drive_frame(1'b0, 8'($urandom), -1, 1'b0);
    base = timeouts;
    @(negedge clk);
    n_cmp++;
    if ({err_frame_n, rx_valid_n, rx_busy_n} !== 3'b100) begin
      n_bad++; $display("FAIL frame_err: ferr,valid,busy got %b want 100", {err_frame_n, rx_valid_n, rx_busy_n});
    end
    repeat (3 * BIT) @(negedge clk);
    n_cmp++;
    if (timeouts - base !== 0) begin n_bad++; $display("FAIL timeout_early: pulses got %0d want 0", timeouts - base); end
    repeat (5 * BIT) @(negedge clk);
    n_cmp++;
    if (timeouts - base !== 1) begin n_bad++; $display("FAIL timeout_once: pulses got %0d want 1", timeouts - base); end
  endtask

  task automatic test_reset_mid_tx();
    logic [7:0] d;
    d = 8'($urandom) & 8'hF7;
    tx_data_n  = d;
    tx_valid_n = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 tx_valid_n = 1'b0;
    repeat (69) @(posedge clk);
    #1;
    n_cmp++;
    if (tx_n !== 1'b0) begin n_bad++; $display("FAIL rst_pre_bit3: tx got %b want 0", tx_n); end
    rst = 1'b0;
    #2;
    n_cmp++;
    if ({tx_n, tx_ready_n, rx_valid_n, rx_busy_n, err_frame_n} !== 5'b11000) begin
      n_bad++; $display("FAIL rst_mid_tx: tx,ready,valid,busy,ferr got %b want 11000",
                        {tx_n, tx_ready_n, rx_valid_n, rx_busy_n, err_frame_n});
    end
    @(posedge clk);
    #1 rst = 1'b1;
    tx_frame(8'h5A, "tx_5a_after_rst");
  endtask

  initial begin
    test_reset();
    test_tx();
    test_rx_random();
    test_glitch();
    test_parity();
    test_overrun();
    test_frame_timeout();
    test_reset_mid_tx();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
